// File: rtl/tinyrv_pkg.sv
// Shared constants and helpers for the tinyrv register file slice.
package tinyrv_pkg;

  localparam int DEF_XLEN  = 16;
  localparam int DEF_NREGS = 8;

  localparam logic [0:0] RF_INIT = 1'b0;
  localparam logic [0:0] RF_RUN  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset clear sweep: walks every register address once, then holds in RUN.
module regfile_init_seq
  import tinyrv_pkg::*;
#(
  parameter  int NREGS = DEF_NREGS,
  localparam int AW    = clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          clr_en,
  output logic [AW-1:0] clr_addr,
  output logic          init_done
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  logic [0:0]    state;
  logic [AW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_INIT;
      cnt   <= '0;
    end else if (state == RF_INIT) begin
      cnt <= cnt + AW'(1);
      if (cnt == LAST) state <= RF_RUN;
    end
  end

  assign clr_en    = (state == RF_INIT);
  assign clr_addr  = cnt;
  assign init_done = (state == RF_RUN);

endmodule

// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with write bypass, busy scoreboard and a
// post-reset clear sweep that must finish before the core issues.
module reg_file_sb
  import tinyrv_pkg::*;
#(
  parameter  int XLEN     = DEF_XLEN,
  parameter  int NREGS    = DEF_NREGS,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rd1_addr,
  input  logic [AW-1:0]   rd2_addr,
  output logic [XLEN-1:0] rd1_data,
  output logic [XLEN-1:0] rd2_data,
  output logic            rd1_busy,
  output logic            rd2_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            claim_en,
  input  logic [AW-1:0]   claim_addr,
  output logic            init_done
);

  logic          clr_en;
  logic [AW-1:0] clr_addr;
  logic          run;

  regfile_init_seq #(.NREGS(NREGS)) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr),
    .init_done (run)
  );

  assign init_done = run;

  logic wr_ok;
  logic clm_ok;

  // Register 0 silently swallows writes and claims when it is hard-wired.
  assign wr_ok  = run && !rst && wr_en    && !(ZERO_REG != 0 && wr_addr == '0);
  assign clm_ok = run && !rst && claim_en && !(ZERO_REG != 0 && claim_addr == '0);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;

  always_ff @(posedge clk) begin
    if (clr_en)     mem[clr_addr] <= '0;
    else if (wr_ok) mem[wr_addr]  <= wr_data;
  end

  // Claim is applied after the write so a same-address pair leaves busy set.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wr_ok)  busy[wr_addr]    <= 1'b0;
      if (clm_ok) busy[claim_addr] <= 1'b1;
    end
  end

  function automatic logic [XLEN:0] read_sel(
    input logic [AW-1:0]   a,
    input logic [XLEN-1:0] md,
    input logic            mb,
    input logic            run_i,
    input logic            w_ok,
    input logic [AW-1:0]   w_addr,
    input logic [XLEN-1:0] w_data,
    input logic            c_ok,
    input logic [AW-1:0]   c_addr
  );
    logic [XLEN-1:0] d;
    logic            b;
    d = md;
    b = mb;
    if (BYPASS != 0) begin
      if (w_ok && w_addr == a) begin
        d = w_data;
        b = 1'b0;
      end
      if (c_ok && c_addr == a) b = 1'b1;
    end
    if (!run_i || (ZERO_REG != 0 && a == '0)) begin
      d = '0;
      b = 1'b0;
    end
    return {b, d};
  endfunction

  logic [XLEN:0] rd1_p0;
  logic [XLEN:0] rd2_p0;

  always_comb begin
    rd1_p0 = read_sel(rd1_addr, mem[rd1_addr], busy[rd1_addr], run,
                      wr_ok, wr_addr, wr_data, clm_ok, claim_addr);
    rd2_p0 = read_sel(rd2_addr, mem[rd2_addr], busy[rd2_addr], run,
                      wr_ok, wr_addr, wr_data, clm_ok, claim_addr);
  end

  // p0 -> p1: registered read port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_data <= '0;
      rd2_data <= '0;
      rd1_busy <= 1'b0;
      rd2_busy <= 1'b0;
    end else begin
      {rd1_busy, rd1_data} <= rd1_p0;
      {rd2_busy, rd2_data} <= rd2_p0;
    end
  end

endmodule
